// File: rtl/mem_stage_pkg.sv
// Shared types, opcode/funct3 constants and access-decode helpers for the memory stage.
package mem_stage_pkg;

    `include "control_signals_struct.svh"

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } mem_state_t;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    // Low offset bits that must be zero for an access of the given size.
    function automatic logic [2:0] align_mask(input logic [1:0] size_code);
        logic [2:0] m;
        case (size_code)
            2'b00:   m = 3'b000;
            2'b01:   m = 3'b001;
            2'b10:   m = 3'b011;
            default: m = 3'b111;
        endcase
        return m;
    endfunction

    // Byte-enable pattern for an access of the given size, before lane shifting.
    function automatic logic [7:0] byte_mask(input logic [1:0] size_code);
        logic [7:0] m;
        case (size_code)
            2'b00:   m = 8'h01;
            2'b01:   m = 8'h03;
            2'b10:   m = 8'h0F;
            default: m = 8'hFF;
        endcase
        return m;
    endfunction

    // A memory op faults on an illegal funct3 or a misaligned offset.
    function automatic logic access_fault(input logic       is_load,
                                          input logic       is_store,
                                          input logic [2:0] funct3,
                                          input logic [2:0] offset);
        logic illegal;
        logic misaligned;
        illegal    = (is_load && (funct3 == 3'b111)) || (is_store && funct3[2]);
        misaligned = (offset & align_mask(funct3[1:0])) != 3'b000;
        return (is_load || is_store) && (illegal || misaligned);
    endfunction

endpackage

// File: rtl/control_signals_struct.svh
// Control bundle handed down the pipeline alongside each instruction.
`ifndef CONTROL_SIGNALS_STRUCT_SVH
`define CONTROL_SIGNALS_STRUCT_SVH

typedef struct packed {
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  dest_reg;
    logic [63:0] pc;
} control_signals_struct;

`endif

// File: rtl/load_data_align.sv
// Extracts the addressed byte/half/word/double from a response doubleword and extends it.
module load_data_align
    import mem_stage_pkg::*;
(
    input  logic [63:0] dcache_resp_data,
    input  logic [2:0]  offset,
    input  logic [2:0]  funct3,
    output logic [63:0] load_value
);

    logic [63:0] shifted;
    logic        sign_en;

    assign shifted = dcache_resp_data >> {offset, 3'b000};
    // funct3[2] selects the unsigned (zero-extending) variants.
    assign sign_en = ~funct3[2];

    // Truncate to the access size, then sign- or zero-extend.
    always_comb begin
        load_value = '0;
        case (funct3[1:0])
            2'b00:   load_value = {{56{sign_en & shifted[7]}},  shifted[7:0]};
            2'b01:   load_value = {{48{sign_en & shifted[15]}}, shifted[15:0]};
            2'b10:   load_value = {{32{sign_en & shifted[31]}}, shifted[31:0]};
            default: load_value = shifted;
        endcase
    end

endmodule

// File: rtl/memory_access_stage.sv
// Pipeline memory stage: latches the execute result, runs one data-cache
// transaction for loads/stores and holds the result until write-back acks.
//
// Request channel: dcache_req_valid rises in REQ and, together with addr/write/
// wdata/strb, stays constant until the cycle where valid && ready are both high;
// that cycle is the transfer. The response channel is valid-only: one
// dcache_resp_valid pulse is taken only in WAIT, so it can never coincide with
// request acceptance. Responses seen in any other state are dropped.
// The datapath assumes DATA_WIDTH == 64 and ADDR_WIDTH <= DATA_WIDTH.
module memory_access_stage
    import mem_stage_pkg::*;
#(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mem_module_enable,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic [DATA_WIDTH-1:0] store_data,
    input  control_signals_struct control_signals,
    output logic                  dcache_req_valid,
    input  logic                  dcache_req_ready,
    output logic [ADDR_WIDTH-1:0] dcache_req_addr,
    output logic                  dcache_req_write,
    output logic [DATA_WIDTH-1:0] dcache_req_wdata,
    output logic [7:0]            dcache_req_strb,
    input  logic                  dcache_resp_valid,
    input  logic [DATA_WIDTH-1:0] dcache_resp_data,
    input  logic                  next_stage_ack,
    output logic [DATA_WIDTH-1:0] loaded_data,
    output logic [DATA_WIDTH-1:0] alu_result_out,
    output control_signals_struct control_signals_out,
    output logic                  mem_fault,
    output logic                  memory_done,
    output mem_state_t            state_dbg
);

    mem_state_t            state_q, state_d;
    logic [DATA_WIDTH-1:0] alu_q;
    control_signals_struct ctrl_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [7:0]            strb_q;
    logic                  write_q;
    logic                  fault_q;
    logic [DATA_WIDTH-1:0] loaded_q;

    logic                  accept_q;
    logic                  in_is_load;
    logic                  in_is_store;
    logic                  in_fault;
    logic [63:0]           align_value;

    // Decode of the incoming instruction, only meaningful while IDLE.
    assign in_is_load  = (control_signals.opcode == OPC_LOAD);
    assign in_is_store = (control_signals.opcode == OPC_STORE);
    assign in_fault    = access_fault(in_is_load, in_is_store,
                                      control_signals.funct3, alu_result[2:0]);
    assign accept_q    = (state_q == ST_IDLE) && mem_module_enable;

    load_data_align u_align (
        .dcache_resp_data (dcache_resp_data),
        .offset           (alu_q[2:0]),
        .funct3           (ctrl_q.funct3),
        .load_value       (align_value)
    );

    // State register; reset abandons any in-flight transaction.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (mem_module_enable) begin
                    if ((in_is_load || in_is_store) && !in_fault) begin
                        state_d = ST_REQ;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_REQ:  if (dcache_req_ready)  state_d = ST_WAIT;
            ST_WAIT: if (dcache_resp_valid) state_d = ST_DONE;
            ST_DONE: if (next_stage_ack)    state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Handshake outputs decoded purely from the state register.
    always_comb begin
        dcache_req_valid = (state_q == ST_REQ);
        memory_done      = (state_q == ST_DONE);
        state_dbg        = state_q;
    end

    // Instruction latch plus captured load value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alu_q    <= '0;
            ctrl_q   <= '0;
            wdata_q  <= '0;
            strb_q   <= '0;
            write_q  <= 1'b0;
            fault_q  <= 1'b0;
            loaded_q <= '0;
        end else if (accept_q) begin
            alu_q    <= alu_result;
            ctrl_q   <= control_signals;
            wdata_q  <= store_data << {alu_result[2:0], 3'b000};
            strb_q   <= byte_mask(control_signals.funct3[1:0]) << alu_result[2:0];
            write_q  <= in_is_store;
            fault_q  <= in_fault;
            loaded_q <= '0;
        end else if ((state_q == ST_WAIT) && dcache_resp_valid && !write_q) begin
            loaded_q <= align_value;
        end
    end

    assign dcache_req_addr     = alu_q[ADDR_WIDTH-1:0];
    assign dcache_req_write    = write_q;
    assign dcache_req_wdata    = wdata_q;
    assign dcache_req_strb     = strb_q;
    assign loaded_data         = loaded_q;
    assign alu_result_out      = alu_q;
    assign control_signals_out = ctrl_q;
    assign mem_fault           = fault_q;

endmodule

// File: tb/tb_memory_access_stage.sv
// Directed bench for memory_access_stage: vector table plus handshake/reset sequences.
module tb_memory_access_stage;
    import mem_stage_pkg::*;

    logic                  clk;
    logic                  reset;
    logic                  mem_module_enable;
    logic [63:0]           alu_result;
    logic [63:0]           store_data;
    control_signals_struct control_signals;
    logic                  dcache_req_valid;
    logic                  dcache_req_ready;
    logic [63:0]           dcache_req_addr;
    logic                  dcache_req_write;
    logic [63:0]           dcache_req_wdata;
    logic [7:0]            dcache_req_strb;
    logic                  dcache_resp_valid;
    logic [63:0]           dcache_resp_data;
    logic                  next_stage_ack;
    logic [63:0]           loaded_data;
    logic [63:0]           alu_result_out;
    control_signals_struct control_signals_out;
    logic                  mem_fault;
    logic                  memory_done;
    mem_state_t            state_dbg;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [6:0] OPC_ADD = 7'b0110011;
    localparam logic [6:0] OPC_LUI = 7'b0110111;

    memory_access_stage #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) dut (
        .clk                 (clk),
        .reset               (reset),
        .mem_module_enable   (mem_module_enable),
        .alu_result          (alu_result),
        .store_data          (store_data),
        .control_signals     (control_signals),
        .dcache_req_valid    (dcache_req_valid),
        .dcache_req_ready    (dcache_req_ready),
        .dcache_req_addr     (dcache_req_addr),
        .dcache_req_write    (dcache_req_write),
        .dcache_req_wdata    (dcache_req_wdata),
        .dcache_req_strb     (dcache_req_strb),
        .dcache_resp_valid   (dcache_resp_valid),
        .dcache_resp_data    (dcache_resp_data),
        .next_stage_ack      (next_stage_ack),
        .loaded_data         (loaded_data),
        .alu_result_out      (alu_result_out),
        .control_signals_out (control_signals_out),
        .mem_fault           (mem_fault),
        .memory_done         (memory_done),
        .state_dbg           (state_dbg)
    );

    // ---------------- clock / watchdog ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected end of test");
        $fatal(1, "watchdog expired");
    end

    // ---------------- vector table ----------------
    typedef struct {
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [63:0] addr;
        logic [63:0] sdata;
        logic [63:0] resp;
        logic        exp_req;
        logic        exp_fault;
        logic [63:0] exp_wdata;
        logic [7:0]  exp_strb;
        logic [63:0] exp_loaded;
    } vec_t;

    localparam int NVEC = 18;
    vec_t vecs[NVEC];

    function automatic vec_t mk(input logic [6:0] opc, input logic [2:0] f3,
                                input logic [63:0] addr, input logic [63:0] sdata,
                                input logic [63:0] resp, input logic exp_req,
                                input logic exp_fault, input logic [63:0] exp_wdata,
                                input logic [7:0] exp_strb, input logic [63:0] exp_loaded);
        vec_t v;
        v.opc = opc; v.f3 = f3; v.addr = addr; v.sdata = sdata; v.resp = resp;
        v.exp_req = exp_req; v.exp_fault = exp_fault; v.exp_wdata = exp_wdata;
        v.exp_strb = exp_strb; v.exp_loaded = exp_loaded;
        return v;
    endfunction

    // ---------------- checker ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " req_valid"}, 64'(dcache_req_valid), 64'd0);
        check({tag, " req_addr"},  dcache_req_addr, 64'd0);
        check({tag, " req_write"}, 64'(dcache_req_write), 64'd0);
        check({tag, " req_wdata"}, dcache_req_wdata, 64'd0);
        check({tag, " req_strb"},  64'(dcache_req_strb), 64'd0);
        check({tag, " done"},      64'(memory_done), 64'd0);
        check({tag, " fault"},     64'(mem_fault), 64'd0);
        check({tag, " loaded"},    loaded_data, 64'd0);
        check({tag, " alu_out"},   alu_result_out, 64'd0);
        check({tag, " ctrl_opc"},  64'(control_signals_out.opcode), 64'd0);
        check({tag, " ctrl_f3"},   64'(control_signals_out.funct3), 64'd0);
        check({tag, " ctrl_rd"},   64'(control_signals_out.dest_reg), 64'd0);
        check({tag, " ctrl_pc"},   control_signals_out.pc, 64'd0);
        check({tag, " state"},     64'(state_dbg), 64'(ST_IDLE));
    endtask

    // ---------------- driver ----------------
    task automatic drive_instr(input logic [6:0] opc, input logic [2:0] f3,
                               input logic [63:0] addr, input logic [63:0] sdata,
                               input logic [4:0] rd, input logic [63:0] pc);
        mem_module_enable       = 1'b1;
        alu_result              = addr;
        store_data              = sdata;
        control_signals.opcode  = opc;
        control_signals.funct3  = f3;
        control_signals.dest_reg = rd;
        control_signals.pc      = pc;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        logic [4:0]  rd;
        logic [63:0] pc;
        string       tag;
        rd  = 5'(idx + 1);
        pc  = 64'h8000_0000 + 64'(idx * 4);
        tag = $sformatf("v%0d", idx);
        @(negedge clk);
        drive_instr(v.opc, v.f3, v.addr, v.sdata, rd, pc);
        @(negedge clk);
        // Scramble inputs to prove the stage works from its latched copy.
        mem_module_enable = 1'b0;
        alu_result        = 64'hFFFF_0000_FFFF_0000;
        store_data        = 64'h0BAD_0BAD_0BAD_0BAD;
        control_signals   = '0;
        if (v.exp_req) begin
            check({tag, " req_valid"}, 64'(dcache_req_valid), 64'd1);
            check({tag, " req_addr"},  dcache_req_addr, v.addr);
            check({tag, " req_write"}, 64'(dcache_req_write), 64'(v.opc == OPC_STORE));
            check({tag, " req_wdata"}, dcache_req_wdata, v.exp_wdata);
            check({tag, " req_strb"},  64'(dcache_req_strb), 64'(v.exp_strb));
            check({tag, " early_done"}, 64'(memory_done), 64'd0);
            dcache_req_ready = 1'b1;
            @(negedge clk);
            dcache_req_ready = 1'b0;
            check({tag, " wait_valid"}, 64'(dcache_req_valid), 64'd0);
            check({tag, " wait_done"},  64'(memory_done), 64'd0);
            dcache_resp_valid = 1'b1;
            dcache_resp_data  = v.resp;
            @(negedge clk);
            dcache_resp_valid = 1'b0;
            dcache_resp_data  = '0;
        end else begin
            check({tag, " no_req"}, 64'(dcache_req_valid), 64'd0);
        end
        check({tag, " done"},     64'(memory_done), 64'd1);
        check({tag, " fault"},    64'(mem_fault), 64'(v.exp_fault));
        check({tag, " loaded"},   loaded_data, v.exp_loaded);
        check({tag, " alu_out"},  alu_result_out, v.addr);
        check({tag, " ctrl_opc"}, 64'(control_signals_out.opcode), 64'(v.opc));
        check({tag, " ctrl_f3"},  64'(control_signals_out.funct3), 64'(v.f3));
        check({tag, " ctrl_rd"},  64'(control_signals_out.dest_reg), 64'(rd));
        check({tag, " ctrl_pc"},  control_signals_out.pc, pc);
        // Without ack the result must be held.
        @(negedge clk);
        check({tag, " hold_done"},   64'(memory_done), 64'd1);
        check({tag, " hold_loaded"}, loaded_data, v.exp_loaded);
        next_stage_ack = 1'b1;
        @(negedge clk);
        next_stage_ack = 1'b0;
        check({tag, " ack_done"},  64'(memory_done), 64'd0);
        check({tag, " ack_state"}, 64'(state_dbg), 64'(ST_IDLE));
    endtask

    // ---------------- test ----------------
    initial begin
        reset             = 1'b0;
        mem_module_enable = 1'b0;
        alu_result        = '0;
        store_data        = '0;
        control_signals   = '0;
        dcache_req_ready  = 1'b0;
        dcache_resp_valid = 1'b0;
        dcache_resp_data  = '0;
        next_stage_ack    = 1'b0;

        //                opc        f3     addr         sdata                  resp                   req fault wdata                  strb   loaded
        vecs[0]  = mk(OPC_ADD,   3'b000, 64'h1234, 64'h77,                64'h0,                 0, 0, 64'h0,                  8'h00, 64'h0);
        vecs[1]  = mk(OPC_LOAD,  F3_B,   64'h1003, 64'h0,                 64'h0000_0000_8000_0000, 1, 0, 64'h0,                8'h08, 64'hFFFF_FFFF_FFFF_FF80);
        vecs[2]  = mk(OPC_LOAD,  F3_BU,  64'h1003, 64'h0,                 64'h0000_0000_8000_0000, 1, 0, 64'h0,                8'h08, 64'h80);
        vecs[3]  = mk(OPC_LOAD,  F3_H,   64'h1006, 64'h0,                 64'h8001_0000_0000_0000, 1, 0, 64'h0,                8'hC0, 64'hFFFF_FFFF_FFFF_8001);
        vecs[4]  = mk(OPC_LOAD,  F3_HU,  64'h1006, 64'h0,                 64'h8001_0000_0000_0000, 1, 0, 64'h0,                8'hC0, 64'h8001);
        vecs[5]  = mk(OPC_LOAD,  F3_WU,  64'h1004, 64'h0,                 64'hDEAD_BEEF_0000_0000, 1, 0, 64'h0,                8'hF0, 64'hDEAD_BEEF);
        vecs[6]  = mk(OPC_LOAD,  F3_D,   64'h3000, 64'h0,                 64'h0123_4567_89AB_CDEF, 1, 0, 64'h0,                8'hFF, 64'h0123_4567_89AB_CDEF);
        vecs[7]  = mk(OPC_LOAD,  F3_B,   64'h1000, 64'h0,                 64'h0000_0000_0000_007F, 1, 0, 64'h0,                8'h01, 64'h7F);
        vecs[8]  = mk(OPC_LOAD,  F3_D,   64'h3004, 64'h0,                 64'h0,                 0, 1, 64'h0,                  8'h00, 64'h0);
        vecs[9]  = mk(OPC_STORE, F3_H,   64'h2002, 64'hABCD,              64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 64'hABCD_0000,        8'h0C, 64'h0);
        vecs[10] = mk(OPC_STORE, F3_B,   64'h2007, 64'h55,                64'h0,                 1, 0, 64'h5500_0000_0000_0000, 8'h80, 64'h0);
        vecs[11] = mk(OPC_STORE, F3_W,   64'h2004, 64'hFFFF_FFFF_1234_5678, 64'h0,               1, 0, 64'h1234_5678_0000_0000, 8'hF0, 64'h0);
        vecs[12] = mk(OPC_STORE, F3_D,   64'h2008, 64'h1122_3344_5566_7788, 64'h0,               1, 0, 64'h1122_3344_5566_7788, 8'hFF, 64'h0);
        vecs[13] = mk(OPC_LOAD,  3'b111, 64'h1000, 64'h0,                 64'h0,                 0, 1, 64'h0,                  8'h00, 64'h0);
        vecs[14] = mk(OPC_STORE, 3'b100, 64'h2000, 64'h1,                 64'h0,                 0, 1, 64'h0,                  8'h00, 64'h0);
        vecs[15] = mk(OPC_STORE, F3_W,   64'h2002, 64'h1,                 64'h0,                 0, 1, 64'h0,                  8'h00, 64'h0);
        vecs[16] = mk(OPC_LOAD,  F3_W,   64'h1002, 64'h0,                 64'h0,                 0, 1, 64'h0,                  8'h00, 64'h0);
        vecs[17] = mk(OPC_LUI,   F3_D,   64'h3004, 64'h0,                 64'h0,                 0, 0, 64'h0,                  8'h00, 64'h0);

        // Reset state, held and after release.
        repeat (2) @(negedge clk);
        check_all_zero("rst");
        reset = 1'b1;
        @(negedge clk);
        check("post_rst done",  64'(memory_done), 64'd0);
        check("post_rst state", 64'(state_dbg), 64'(ST_IDLE));

        for (int i = 0; i < NVEC; i++) begin
            run_vec(vecs[i], i);
        end

        // LW with a stalled request channel; stray response and new enables are ignored.
        @(negedge clk);
        drive_instr(OPC_LOAD, F3_W, 64'h1004, 64'h5555, 5'd9, 64'h100);
        @(negedge clk);
        drive_instr(OPC_ADD, 3'b000, 64'h9999, 64'h0, 5'd1, 64'h0);
        for (int c = 0; c < 3; c++) begin
            check($sformatf("stall%0d valid", c), 64'(dcache_req_valid), 64'd1);
            check($sformatf("stall%0d addr", c),  dcache_req_addr, 64'h1004);
            check($sformatf("stall%0d write", c), 64'(dcache_req_write), 64'd0);
            check($sformatf("stall%0d wdata", c), dcache_req_wdata, 64'h0000_5555_0000_0000);
            check($sformatf("stall%0d strb", c),  64'(dcache_req_strb), 64'hF0);
            dcache_resp_valid = (c == 1);
            dcache_resp_data  = 64'hFFFF_FFFF_FFFF_FFFF;
            @(negedge clk);
        end
        dcache_resp_valid = 1'b0;
        check("stall state", 64'(state_dbg), 64'(ST_REQ));
        dcache_req_ready = 1'b1;
        @(negedge clk);
        dcache_req_ready  = 1'b0;
        mem_module_enable = 1'b0;
        check("stall wait_state", 64'(state_dbg), 64'(ST_WAIT));
        dcache_resp_valid = 1'b1;
        dcache_resp_data  = 64'hDEAD_BEEF_0000_0000;
        @(negedge clk);
        dcache_resp_valid = 1'b0;
        check("stall done",    64'(memory_done), 64'd1);
        check("stall loaded",  loaded_data, 64'hFFFF_FFFF_DEAD_BEEF);
        check("stall alu_out", alu_result_out, 64'h1004);
        check("stall rd",      64'(control_signals_out.dest_reg), 64'd9);
        next_stage_ack = 1'b1;
        @(negedge clk);
        next_stage_ack = 1'b0;

        // Reset during WAIT, response one cycle later must be ignored.
        @(negedge clk);
        drive_instr(OPC_LOAD, F3_B, 64'h1003, 64'h0, 5'd3, 64'h200);
        @(negedge clk);
        mem_module_enable = 1'b0;
        dcache_req_ready  = 1'b1;
        @(negedge clk);
        dcache_req_ready = 1'b0;
        check("rstw state_before", 64'(state_dbg), 64'(ST_WAIT));
        #2 reset = 1'b0;
        #1 check_all_zero("rstw");
        @(negedge clk);
        reset             = 1'b1;
        dcache_resp_valid = 1'b1;
        dcache_resp_data  = 64'h0000_0000_8000_0000;
        @(negedge clk);
        dcache_resp_valid = 1'b0;
        check("rstw late_done",   64'(memory_done), 64'd0);
        check("rstw late_state",  64'(state_dbg), 64'(ST_IDLE));
        check("rstw late_loaded", loaded_data, 64'd0);
        run_vec(vecs[1], 1);

        // Back-to-back pass-through: ack in first DONE cycle, enable ignored in DONE.
        @(negedge clk);
        drive_instr(OPC_ADD, 3'b000, 64'hA, 64'h0, 5'd4, 64'h300);
        @(negedge clk);
        check("b2b done1",   64'(memory_done), 64'd1);
        check("b2b alu1",    alu_result_out, 64'hA);
        check("b2b loaded1", loaded_data, 64'd0);
        next_stage_ack = 1'b1;
        alu_result     = 64'hB;
        @(negedge clk);
        next_stage_ack = 1'b0;
        check("b2b idle",  64'(memory_done), 64'd0);
        check("b2b alu_hold", alu_result_out, 64'hA);
        @(negedge clk);
        mem_module_enable = 1'b0;
        check("b2b done2", 64'(memory_done), 64'd1);
        check("b2b alu2",  alu_result_out, 64'hB);
        next_stage_ack = 1'b1;
        @(negedge clk);
        next_stage_ack = 1'b0;
        check("b2b end_state", 64'(state_dbg), 64'(ST_IDLE));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/memory_access_stage.md
# memory_access_stage

Pipeline memory stage between execute and write-back. Latches the execute result, issues load/store requests to the data cache over a valid/ready request channel and a valid-only response channel, and aligns and sign-extends load data. Presents `loaded_data`, the passed-through ALU result and control signals to write-back, and holds them until write-back acknowledges.

## Interface
Parameters:
- `ADDR_WIDTH`, 64, data-cache address width
- `DATA_WIDTH`, 64, register and cache-line-word width

Ports:
- `clk`  in  1  single clock; all state on rising edge
- `reset`  in  1  asynchronous, active-low; asserting it (0) clears all state immediately
- `mem_module_enable`  in  1  valid instruction present from execute
- `alu_result`  in  64  ALU result / effective address
- `store_data`  in  64  rs2 value for stores
- `control_signals`  in  `control_signals_struct`  uses `opcode`, `funct3`, `dest_reg`, `pc`
- `dcache_req_valid`  out  1  request valid
- `dcache_req_ready`  in  1  cache accepts request
- `dcache_req_addr`  out  64  byte address
- `dcache_req_write`  out  1  1 = store
- `dcache_req_wdata`  out  64  store data, lane-shifted
- `dcache_req_strb`  out  8  byte-enable mask
- `dcache_resp_valid`  in  1  response/ack, one cycle
- `dcache_resp_data`  in  64  aligned doubleword containing the address
- `next_stage_ack`  in  1  write-back has consumed the result
- `loaded_data`  out  64  aligned, extended load value
- `alu_result_out`  out  64  latched `alu_result`
- `control_signals_out`  out  `control_signals_struct`  latched control signals
- `mem_fault`  out  1  misaligned access or illegal `funct3`
- `memory_done`  out  1  outputs valid for write-back

## Operation
- FSM states: IDLE, REQ, WAIT, DONE. Reset state IDLE.
- IDLE: on `mem_module_enable`, latch `alu_result`, `store_data`, `control_signals`.
  - Load (0000011) or store (0100011) with legal, aligned access -> REQ.
  - Faulting memory op -> DONE with `mem_fault`=1, `loaded_data`=0, no cache request.
  - Any other opcode -> DONE directly (pass-through).
- REQ: `dcache_req_valid`=1.
  - addr/write/wdata/strb are held constant until accepted.
  - `valid && ready` -> WAIT.
- WAIT: on `dcache_resp_valid`, capture the extracted load value (stores ignore the data) -> DONE.
- DONE: `memory_done`=1; all outputs stable; `next_stage_ack` -> IDLE.
- Offset = `addr[2:0]`; size = `funct3[1:0]` (1/2/4/8 bytes).
- Misaligned when offset is not a multiple of the size.
- Legal load funct3: 000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU; 111 is illegal.
- Legal store funct3: 000–011; all others are illegal.
- Load extract: `dcache_resp_data >> (offset*8)`, truncate to size, then sign-extend (funct3[2]=0) or zero-extend (funct3[2]=1).
- Store: wdata = `store_data << (offset*8)`; strb = ((1<<size)-1) << offset.
- `dcache_req_addr` = full latched address (not doubleword-aligned).
- Non-load instructions: `loaded_data`=0.

## Timing
- Reset (asynchronous, active-low): state IDLE; every output 0, including `dcache_req_valid`, `memory_done`, `mem_fault`, `loaded_data`, `alu_result_out` and `control_signals_out` (all fields).
- Reset mid-REQ or mid-WAIT abandons the transaction. A `dcache_resp_valid` arriving after reset is ignored because IDLE ignores responses.
- All outputs are registered or decoded from the state register; no combinational path from inputs to outputs.
- Pass-through latency: enable in cycle 0 -> `memory_done` in cycle 1.
- Load/store minimum latency: enable in cycle 0, request in cycle 1 (ready=1), response in cycle 2 -> `memory_done` in cycle 3.
- The response is never accepted in the same cycle as request acceptance.
- `mem_module_enable` is ignored outside IDLE.
- An ack in the first DONE cycle returns to IDLE the next cycle, so back-to-back pass-through throughput is one instruction per 2 cycles.
- `dcache_resp_valid` in REQ or DONE is a protocol error and is ignored.

## Structure
- Shared package `mem_stage_pkg` holds:
  - state enum `mem_state_t`
  - opcode constants `OPC_LOAD` and `OPC_STORE`
  - funct3 constants for load/store widths
- `control_signals_struct` stays in `control_signals_struct.svh`.
- One combinational sub-module, `load_data_align`: inputs `dcache_resp_data`, offset, funct3; output a 64-bit extended value.

## Test plan
- ADD (opcode 0110011), `alu_result`=0x1234 -> cycle 1: `memory_done`=1, `alu_result_out`=0x1234, `loaded_data`=0, no `dcache_req_valid`.
- LB at addr 0x1003, resp 0x0000_0000_8000_0000 -> `loaded_data`=0xFFFF_FFFF_FFFF_FF80. LBU at the same address -> 0x80.
- LW at 0x1004, `dcache_req_ready` low for 3 cycles -> req fields stable throughout. Resp 0xDEAD_BEEF_0000_0000 -> `loaded_data`=0xFFFF_FFFF_DEAD_BEEF.
- SH at 0x2002, `store_data`=0xABCD -> wdata=0xABCD_0000, strb=0x0C, write=1. DONE after response.
- LD at 0x3004 -> no request, `mem_fault`=1, `memory_done` next cycle. Load with funct3=111 -> same.
- Reset low during WAIT, response pulses 1 cycle later -> all outputs 0, state IDLE, response ignored. Following load completes normally.
